stream_logic_reducer: RTL and testbench

- Parametrised, sequential successor to the team's fixed-function bitwise gates.
- Folds a stream of LEN WIDTH-bit words into one word using a selectable bitwise operation: AND, OR, XOR or NOR-reduce.
- Valid/ready handshakes on input and output.
- Sits between a word source and the ALU-side result path in the homework CPU datapath.

---
 rtl/logic_pkg.sv | 32 +++
 rtl/stream_logic_reducer_bitwise_op.sv | 30 +++
 rtl/stream_logic_reducer.sv | 118 +++++++++++
 tb/tb_stream_logic_reducer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// ---------------------------------------------------------------------------
// logic_pkg : shared mode/state encodings and reduction identity helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package logic_pkg;

  // Widest word the identity helper can serve; callers truncate to their WIDTH.
  localparam int MAX_W = 1024;

  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_OR  = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // NOR folds as OR and inverts at the end, so only AND starts from all ones.
  function automatic logic [MAX_W-1:0] identity(input logic [1:0] mode);
    return (mode == MODE_AND) ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_logic_reducer_bitwise_op.sv
// ---------------------------------------------------------------------------
// bitwise_op : combinational WIDTH-bit AND / OR / XOR / NOR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bitwise_op
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      MODE_AND: y = a & b;
      MODE_OR:  y = a | b;
      MODE_XOR: y = a ^ b;
      default:  y = ~(a | b);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stream_logic_reducer.sv
// ---------------------------------------------------------------------------
// stream_logic_reducer : folds LEN words into one with a bitwise op
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_logic_reducer
  import logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             busy
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out_data;
  logic [LEN_W-1:0] r_rem;
  logic [1:0]       r_mode;

  logic [WIDTH-1:0] w_ident;
  logic [WIDTH-1:0] w_op_y;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_result;
  logic [1:0]       w_op_sel;
  logic [1:0]       w_load_mode;
  logic             w_beat;
  logic             w_last;

  assign w_ident  = WIDTH'(identity(mode));
  assign w_beat   = (r_state == ST_ACCUM) && in_valid;
  assign w_last   = w_beat && (r_rem == LEN_W'(1));
  // Accumulation for NOR is a plain OR; the inversion is applied once on the result.
  assign w_op_sel = (r_mode == MODE_NOR) ? MODE_OR : r_mode;

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .a  (r_acc),
    .b  (in_data),
    .op (w_op_sel),
    .y  (w_op_y)
  );

  // Result is captured on entry to DONE so out_data is a pure register.
  assign w_load_val  = (r_state == ST_IDLE) ? w_ident : w_op_y;
  assign w_load_mode = (r_state == ST_IDLE) ? mode : r_mode;
  assign w_result    = (w_load_mode == MODE_NOR) ? ~w_load_val : w_load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (w_last) w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_rem      <= '0;
      r_mode     <= MODE_AND;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_acc  <= w_ident;
            r_rem  <= len;
            if (len == '0) r_out_data <= w_result;
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_op_y;
            if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
            if (w_last) r_out_data <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == ST_ACCUM);
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
    out_zero  = out_valid && (r_out_data == '0);
    out_ones  = out_valid && (&r_out_data);
  end

  assign out_data = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_stream_logic_reducer.sv
// ---------------------------------------------------------------------------
// tb_stream_logic_reducer : directed + random jobs against a fold model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_logic_reducer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [3:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_ones;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] words[$];
  logic [15:0] held;

  stream_logic_reducer #(.WIDTH(16), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_ones(out_ones), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: fold the word list with plain operators, NOR = invert of the OR fold.
  function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] w[$]);
    logic [15:0] a;
    a = (m == 2'b00) ? 16'hFFFF : 16'h0000;
    foreach (w[i]) begin
      case (m)
        2'b00:   a = a & w[i];
        2'b10:   a = a ^ w[i];
        default: a = a | w[i];
      endcase
    end
    return (m == 2'b11) ? ~a : a;
  endfunction

  task automatic begin_job(input logic [1:0] m, input int n);
    start = 1'b1; mode = m; len = 4'(n);
    step();
    start = 1'b0;
    check("busy_after_start", {15'd0, busy}, 16'd1);
  endtask

  // Feeds words[] with 0..max_gap stall cycles before each beat; optionally
  // pulses a conflicting start during the stall before the second beat.
  task automatic feed(input int max_gap, input bit poke);
    for (int i = 0; i < words.size(); i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (poke && i == 1 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        if (poke && i == 1 && g == 0) begin
          start = 1'b1; mode = 2'b01; len = 4'd1;
        end
        step();
        start = 1'b0;
        check("in_ready_stall", {15'd0, in_ready}, 16'd1);
        check("no_early_valid", {15'd0, out_valid}, 16'd0);
      end
      in_valid = 1'b1;
      in_data  = words[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input logic [1:0] m, input int hold);
    logic [15:0] e;
    e = model(m, words);
    check("out_valid", {15'd0, out_valid}, 16'd1);
    check("out_data", out_data, e);
    check("out_zero", {15'd0, out_zero}, {15'd0, e == 16'h0000});
    check("out_ones", {15'd0, out_ones}, {15'd0, e == 16'hFFFF});
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      step();
      check("hold_valid", {15'd0, out_valid}, 16'd1);
      check("hold_data", out_data, e);
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake(input bit with_start);
    out_ready = 1'b1;
    start = with_start; mode = 2'b00; len = 4'd1;
    step();
    out_ready = 1'b0; start = 1'b0;
    check("idle_after_hs", {15'd0, busy}, 16'd0);
    check("valid_drop", {15'd0, out_valid}, 16'd0);
  endtask

  task automatic run_job(input logic [1:0] m, input int max_gap, input int hold);
    begin_job(m, words.size());
    feed(max_gap, 1'b0);
    check_result(m, hold);
    handshake(1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; len = 4'd0;
    in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_out_data", out_data, 16'd0);
    reset = 1'b0;
    step();

    // OR, continuous beats
    words = '{16'h0001, 16'h0010, 16'h0100};
    run_job(2'b01, 0, 0);
    // AND with a 3-cycle gap between beats
    words = '{16'hFFFF, 16'h0F0F};
    begin_job(2'b00, 2);
    in_valid = 1'b1; in_data = words[0]; step();
    for (int g = 0; g < 3; g++) begin
      in_valid = 1'b0; in_data = 16'h0000; step();
      check("and_gap_ready", {15'd0, in_ready}, 16'd1);
    end
    in_valid = 1'b1; in_data = words[1]; step();
    in_valid = 1'b0;
    check_result(2'b00, 0);
    handshake(1'b0);
    // NOR -> zero, XOR -> ones
    words = '{16'hAAAA, 16'h5555};
    run_job(2'b11, 1, 0);
    run_job(2'b10, 1, 0);

    // AND len=0 with in_valid held high: nothing consumed, result held 5 cycles
    words.delete();
    in_valid = 1'b1; in_data = 16'h0000;
    begin_job(2'b00, 0);
    check("len0_no_ready", {15'd0, in_ready}, 16'd0);
    check_result(2'b00, 5);
    handshake(1'b0);

    // start pulse mid-ACCUM ignored; start during out handshake ignored
    words = '{16'h1357, 16'h2468, 16'h0FF0};
    begin_job(2'b10, 3);
    feed(2, 1'b1);
    check_result(2'b10, 1);
    handshake(1'b1);
    words = '{16'hC3C3};
    begin_job(2'b01, 1);
    feed(0, 1'b0);
    check_result(2'b01, 0);
    handshake(1'b0);

    // asynchronous reset mid-job
    words = '{16'hFFFF};
    begin_job(2'b01, 3);
    feed(0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", {15'd0, in_ready}, 16'd0);
    check("arst_out_valid", {15'd0, out_valid}, 16'd0);
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_out_data", out_data, 16'd0);
    #2 reset = 1'b0;
    step();
    words = '{16'h1234};
    run_job(2'b01, 0, 0);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      logic [1:0] m;
      int n;
      m = 2'($urandom_range(3, 0));
      n = int'($urandom_range(15, 0));
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(16'($urandom));
      run_job(m, 2, int'($urandom_range(2, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
